// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: pass-through of the EXE->MEM fields plus a
// multi-cycle load/store to an internal word-addressed data memory. Upstream is frozen
// while an access is in flight.
// Optional feature: define MEM_ALIGN_CHECK_EN to suppress misaligned accesses and pulse
// misaligned in the DONE cycle.
module mem_access_stage #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned BASE_ADDR = 1024,
    parameter int unsigned LATENCY   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic              wb_en_in,
    input  logic [4:0]        dest_in,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] st_val,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic [4:0]        dest_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] mem_read_val,
    output logic              freeze,
    output logic              misaligned
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] offset;
    logic [DATA_W-1:0] word_idx;
    logic              in_range;
    logic              aligned;
    logic              access_ok;
    logic              req;
    logic              do_access;
    logic              we;
    logic              rd_hit;
    logic              freeze_c;

    // Pass-through to the MEM->WB register, independent of the FSM.
    always_comb begin
        wb_en_out    = wb_en_in;
        mem_r_en_out = mem_r_en;
        dest_out     = dest_in;
        alu_res_out  = alu_res;
    end

    // Address decode: byte address relative to BASE_ADDR, truncated to a word index.
    always_comb begin
        offset    = alu_res - DATA_W'(BASE_ADDR);
        word_idx  = offset >> 2;
        in_range  = (alu_res >= DATA_W'(BASE_ADDR)) && (word_idx < DATA_W'(DEPTH));
`ifdef MEM_ALIGN_CHECK_EN
        aligned   = (alu_res[1:0] == 2'b00);
`else
        aligned   = 1'b1;
`endif
        access_ok = in_range && aligned;
        req       = mem_r_en | mem_w_en;
        do_access = (state_q == StWait) && (cnt_q == 4'd0);
        // Store wins when both enables are set, so the load path sees nothing.
        we        = do_access && mem_w_en && access_ok;
        rd_hit    = mem_r_en && !mem_w_en && access_ok;
    end

    // Next-state, wait counter and read capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        freeze_c = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    freeze_c = 1'b1;
                    cnt_d    = 4'(LATENCY - 1);
                    state_d  = StWait;
                end
            end
            StWait: begin
                freeze_c = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d = rd_hit ? mem[word_idx[AW-1:0]] : '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state, counter and captured read data; reset abandons any access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Data array; not cleared by reset, written only on the WAIT->DONE edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[word_idx[AW-1:0]] <= st_val;
        end
    end

    // Outputs; reset forces freeze low even while upstream still presents a request.
    always_comb begin
        freeze       = freeze_c & ~rst;
        mem_read_val = (state_q == StDone) ? rdata_q : '0;
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic mis_q, mis_d;

    // Remember whether the access just performed was misaligned.
    always_comb begin
        mis_d = do_access ? (alu_res[1:0] != 2'b00) : mis_q;
    end

    // Misalignment flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    // Pulse only during DONE.
    always_comb begin
        misaligned = (state_q == StDone) && mis_q;
    end
`else
    // Alignment checking disabled.
    always_comb begin
        misaligned = 1'b0;
    end
`endif

endmodule
